// File: rtl/reg_fork_2.sv
// reg_fork_2: two-entry register fork, one producer stream to two consumers.
// Every accepted word is delivered exactly once to each consumer, in order;
// the consumers advance independently and one may lead the other by up to
// two words.
//
// Clock is clkrst_core_clk (rising edge). Reset is clkrst_core_rst,
// asynchronous and active-high; it discards all stored words.
//
// Optional feature: define REG_FORK_2_STALL_CNT_EN to add the 16-bit
// saturating producer stall counter on output stall_cnt.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1 in the cycle before it. Valid, once raised, stays high with stable
// data until the transfer. in_ready, out0_valid and out1_valid come from
// registered state only, with no combinational path from any input.
module reg_fork_2 #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic [WIDTH-1:0] D,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             out0_valid,
    output logic             out1_valid,
    input  logic             out0_ready,
    input  logic             out1_ready
`ifdef REG_FORK_2_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Pointers are 2 bits: bit 0 indexes the entry, bit 1 is the wrap bit
    // that tells "full" (differ by 2) from "empty" (equal).
    logic [1:0]       r_wr;
    logic [1:0]       r_rd0;
    logic [1:0]       r_rd1;
    logic [WIDTH-1:0] r_mem [2];

    logic [1:0] w_occ0;
    logic [1:0] w_occ1;
    logic [1:0] w_occ_max;
    logic       w_accept;
    logic       w_consume0;
    logic       w_consume1;

    // Words still owed to each consumer; the slower consumer bounds occupancy.
    assign w_occ0    = r_wr - r_rd0;
    assign w_occ1    = r_wr - r_rd1;
    assign w_occ_max = (w_occ0 > w_occ1) ? w_occ0 : w_occ1;

    assign in_ready   = (w_occ_max < 2'd2);
    assign out0_valid = (r_rd0 != r_wr);
    assign out1_valid = (r_rd1 != r_wr);
    assign Q0         = r_mem[r_rd0[0]];
    assign Q1         = r_mem[r_rd1[0]];

    assign w_accept   = in_valid & in_ready;
    assign w_consume0 = out0_valid & out0_ready;
    assign w_consume1 = out1_valid & out1_ready;

    // Write pointer and storage: capture D into the entry at the write index.
    // An entry is only reachable here once both readers have passed it,
    // because in_ready is low while the slower reader still owes two words.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_wr     <= 2'd0;
            r_mem[0] <= RESET_VAL;
            r_mem[1] <= RESET_VAL;
        end else if (w_accept) begin
            r_wr            <= r_wr + 2'd1;
            r_mem[r_wr[0]]  <= D;
        end
    end

    // Consumer 0 read pointer advances on its own handshake only.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_rd0 <= 2'd0;
        end else if (w_consume0) begin
            r_rd0 <= r_rd0 + 2'd1;
        end
    end

    // Consumer 1 read pointer advances on its own handshake only.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_rd1 <= 2'd0;
        end else if (w_consume1) begin
            r_rd1 <= r_rd1 + 2'd1;
        end
    end

`ifdef REG_FORK_2_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where the producer offers a word that is refused;
    // hold at all-ones instead of wrapping.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_stall_cnt <= 16'd0;
        end else if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
